// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM encoding and default widths.
// Single point of truth for the state encoding seen in waveforms.
package mem_port_arbiter_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DATA       = 2'd1,
    ST_FETCH      = 2'd2,
    ST_FETCH_KILL = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between fetch and data ports, data first; request->valid 1 cycle,
// ready->done 1 cycle. Requesters hold req until done; the memory backpressures by withholding mem_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [XLEN-1:0]     if_rdata,
  output logic                if_done,

  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [XLEN-1:0]     dm_wdata,
  input  logic [XLEN/8-1:0]   dm_wstrb,
  output logic [XLEN-1:0]     dm_rdata,
  output logic                dm_done,

  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ready,

  output logic                stall_if,
  output logic                stall_mem
);

  arb_state_e          state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [XLEN/8-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]     dm_rdata_q, dm_rdata_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;

  logic                dm_elig;
  logic                if_elig;

  // A requester still holding req during its own done cycle must not be re-issued.
  assign dm_elig = dm_req & ~dm_done_q;
  assign if_elig = if_req & ~if_done_q & ~if_flush;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dm_elig) begin
          state_d     = ST_DATA;
          mem_valid_d = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wstrb_d = dm_wstrb;
        end else if (if_elig) begin
          state_d     = ST_FETCH;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wstrb_d = '0;
        end
      end

      ST_DATA: begin
        if (mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          dm_done_d   = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end

      // The memory cannot cancel, so a flushed fetch still runs to mem_ready, silently.
      ST_FETCH: begin
        if (mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
          if (!if_flush) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (if_flush) begin
          state_d = ST_FETCH_KILL;
        end
      end

      ST_FETCH_KILL: begin
        if (mem_ready) begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;

  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions against a wait-state memory model,
// plus hand sequences for arbitration, flush and reset corners; done data checked via scoreboard queues.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_wstrb  (dm_wstrb),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: word array indexed by addr[9:2], mem_ready after wait_cfg stalled cycles.
  logic [31:0] tb_mem [256];
  bit          mem_inited = 1'b0;
  int          wait_cfg;
  int          wait_cnt = 0;

  assign mem_ready = mem_valid && (wait_cnt == wait_cfg);
  assign mem_rdata = mem_ready ? tb_mem[mem_addr[9:2]] : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hC0DE0000 | i;
      tb_mem[64] <= 32'hDEADBEEF;
      mem_inited <= 1'b1;
    end else if (mem_ready && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) tb_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] txn_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_done) begin
        if (dm_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dm_done: got dm_done=1 want 0 (rdata %h)", dm_rdata);
        end else check("dm_rdata", dm_rdata, dm_q.pop_front());
        check("dm_done_valid_low", 32'(mem_valid), 32'd0);
      end
      if (if_done) begin
        if (if_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_if_done: got if_done=1 want 0 (rdata %h)", if_rdata);
        end else check("if_rdata", if_rdata, if_q.pop_front());
        check("if_done_valid_low", 32'(mem_valid), 32'd0);
      end
      if (mem_valid && mem_ready) txn_q.push_back(mem_addr);
    end
  end

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    bit   done;
    logic act_done;
    logic stall;
    @(posedge clk); #1;
    wait_cfg = v.waits;
    txn_q.delete();
    if (v.is_data) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_wstrb = v.wstrb;
      dm_q.push_back(v.exp);
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      if_q.push_back(v.exp);
    end
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      act_done = v.is_data ? dm_done : if_done;
      stall    = v.is_data ? stall_mem : stall_if;
      check("vec_mem_valid", 32'(mem_valid), 32'(c >= 1 && c <= v.waits + 1));
      check("vec_stall", 32'(stall), 32'(c < v.waits + 2));
      if (mem_valid) begin
        check("vec_mem_addr", mem_addr, v.addr);
        check("vec_mem_we", 32'(mem_we), 32'(v.is_data && v.we));
        check("vec_mem_wstrb", 32'(mem_wstrb), 32'(v.is_data ? v.wstrb : 4'h0));
        if (v.is_data && v.we) check("vec_mem_wdata", mem_wdata, v.wdata);
      end
      if (act_done) begin
        check("vec_done_latency", 32'(c), 32'(v.waits + 2));
        done = 1'b1;
      end
    end
    check("vec_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = 4'h0;
    @(negedge clk);
    check("vec_no_reissue", 32'(mem_valid), 32'd0);
    check("vec_txn_count", 32'(txn_q.size()), 32'd1);
    if (txn_q.size() == 1) check("vec_txn_addr", txn_q[0], v.addr);
  endtask

  bit done;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b0, 32'h040, 32'h0,        4'h0, 1, 32'hC0DE0010};
    vecs[2] = '{1'b1, 1'b1, 32'h020, 32'h11223344, 4'h3, 2, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h020, 32'h0,        4'h0, 0, 32'hC0DE3344};
    vecs[4] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        4'h0, 3, 32'hC0DE00FF};
    vecs[5] = '{1'b1, 1'b1, 32'h3FC, 32'hAABBCCDD, 4'hC, 1, 32'hC0DE3344};
    vecs[6] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'h0, 2, 32'hAABB00FF};
    vecs[7] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        4'h0, 0, 32'hAABB00FF};

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    wait_cfg = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_done", 32'(if_done), 32'd0);
    check("rst_dm_done", 32'(dm_done), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Simultaneous store and fetch, 2-wait memory: data goes first.
    @(posedge clk); #1;
    wait_cfg = 2; txn_q.delete();
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678; dm_wstrb = 4'hF;
    dm_q.push_back(32'hAABB00FF);
    if_q.push_back(32'hC0DE0010);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 5) begin dm_req = 1'b0; dm_we = 1'b0; end
      end
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        check("sim_st_valid", 32'(mem_valid), 32'd1);
        check("sim_st_addr", mem_addr, 32'h200);
        check("sim_st_we", 32'(mem_we), 32'd1);
        check("sim_st_wdata", mem_wdata, 32'h12345678);
        check("sim_st_wstrb", 32'(mem_wstrb), 32'hF);
      end
      if (c == 4) check("sim_dm_done_cycle", 32'(dm_done), 32'd1);
      if (c == 5) begin
        check("sim_if_valid", 32'(mem_valid), 32'd1);
        check("sim_if_addr", mem_addr, 32'h40);
        check("sim_if_we", 32'(mem_we), 32'd0);
        check("sim_if_wstrb", 32'(mem_wstrb), 32'd0);
      end
      check("sim_stall_if", 32'(stall_if), 32'(c < 8));
      if (if_done) begin
        check("sim_if_latency", 32'(c), 32'd8);
        done = 1'b1;
      end
    end
    check("sim_timeout", 32'(done), 32'd1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    check("sim_txn_count", 32'(txn_q.size()), 32'd2);
    if (txn_q.size() == 2) begin
      check("sim_txn0", txn_q[0], 32'h200);
      check("sim_txn1", txn_q[1], 32'h40);
    end

    // Flush in the second wait cycle of a 3-wait fetch; redirect to 0xC0.
    @(posedge clk); #1;
    wait_cfg = 3; txn_q.delete();
    if_req = 1'b1; if_addr = 32'h80;
    if_q.push_back(32'hC0DE0030);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 2) begin if_flush = 1'b1; if_addr = 32'hC0; end
        if (c == 3) if_flush = 1'b0;
      end
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        check("fk_valid_held", 32'(mem_valid), 32'd1);
        check("fk_addr_held", mem_addr, 32'h80);
      end
      if (c == 5) begin
        check("fk_idle_valid", 32'(mem_valid), 32'd0);
        check("fk_no_done", 32'(if_done), 32'd0);
        check("fk_rdata_kept", if_rdata, 32'hC0DE0010);
      end
      if (c == 6) check("fk_new_addr", mem_addr, 32'hC0);
      if (if_done) begin
        check("fk_latency", 32'(c), 32'd10);
        done = 1'b1;
      end
    end
    check("fk_timeout", 32'(done), 32'd1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    check("fk_txn_count", 32'(txn_q.size()), 32'd2);
    if (txn_q.size() == 2) begin
      check("fk_txn0", txn_q[0], 32'h80);
      check("fk_txn1", txn_q[1], 32'hC0);
    end

    // Flush coincident with mem_ready: no done, IDLE next cycle issues the redirect.
    @(posedge clk); #1;
    wait_cfg = 1; txn_q.delete();
    if_req = 1'b1; if_addr = 32'h84;
    if_q.push_back(32'hC0DE0022);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 2) begin if_flush = 1'b1; if_addr = 32'h88; end
        if (c == 3) if_flush = 1'b0;
      end
      @(negedge clk);
      if (c == 2) check("fr_ready_cycle", 32'(mem_ready), 32'd1);
      if (c == 3) begin
        check("fr_idle_valid", 32'(mem_valid), 32'd0);
        check("fr_no_done", 32'(if_done), 32'd0);
      end
      if (c == 4) begin
        check("fr_new_valid", 32'(mem_valid), 32'd1);
        check("fr_new_addr", mem_addr, 32'h88);
      end
      if (if_done) begin
        check("fr_latency", 32'(c), 32'd6);
        done = 1'b1;
      end
    end
    check("fr_timeout", 32'(done), 32'd1);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    check("fr_txn_count", 32'(txn_q.size()), 32'd2);

    // Reset during a DATA wait state.
    @(posedge clk); #1;
    wait_cfg = 5; txn_q.delete();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    repeat (3) @(negedge clk);
    check("rd_valid_before", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rd_valid_async", 32'(mem_valid), 32'd0);
    check("rd_addr_clr", mem_addr, 32'd0);
    check("rd_dm_rdata_clr", dm_rdata, 32'd0);
    check("rd_if_rdata_clr", if_rdata, 32'd0);
    @(posedge clk); #1; dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rd_no_done", 32'(dm_done), 32'd0);
      check("rd_idle", 32'(mem_valid), 32'd0);
    end
    check("rd_txn_count", 32'(txn_q.size()), 32'd0);
    run_vec(vecs[0]);

    check("end_if_q_empty", 32'(if_q.size()), 32'd0);
    check("end_dm_q_empty", 32'(dm_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between instruction fetch (IF) and data access (MEM stage) of the pipelined core.
- Owns the memory handshake and sequences one transaction at a time.
- Returns read data and completion pulses to each requester.
- Produces stall requests that the pipeline hazard logic ORs into its IF/MEM stalls.

Parameters:
- XLEN, 32, data width of memory and requesters
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch/jump redirect (ex_pc_src); in-flight fetch result is discarded
- if_rdata  out  XLEN  fetched instruction, valid when if_done
- if_done  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  XLEN  store data
- dm_wstrb  in  XLEN/8  byte-enable for store
- dm_rdata  out  XLEN  load data, valid when dm_done
- dm_done  out  1  one-cycle completion pulse for data
- mem_valid  out  1  memory request valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  XLEN  memory write data
- mem_wstrb  out  XLEN/8  memory byte enables
- mem_rdata  in  XLEN  memory read data, valid with mem_ready
- mem_ready  in  1  transaction accepted and complete this cycle
- stall_if  out  1  = if_req & ~if_done
- stall_mem  out  1  = dm_req & ~dm_done

Behaviour:
- FSM states: IDLE, DATA, FETCH, FETCH_KILL.
- Reset (async, rst_n = 0):
  - State returns to IDLE.
  - All registered outputs clear: mem_valid, mem_we, if_done, dm_done = 0; mem_addr, mem_wdata, mem_wstrb, if_rdata, dm_rdata = 0.
  - A reset mid-transaction abandons it; no done pulse is produced.
- IDLE:
  - Eligible data request: dm_req & ~dm_done. Eligible fetch request: if_req & ~if_done & ~if_flush.
  - A requester whose done pulse is high this cycle is ignored. This prevents re-issuing a held request.
  - If data is eligible, latch dm_we/addr/wdata/wstrb into the mem_* registers and go to DATA.
  - Else if fetch is eligible, latch if_addr with mem_we = 0 and wstrb = 0, and go to FETCH.
  - Simultaneous requests: data wins, and fetch waits.
- DATA, FETCH, FETCH_KILL:
  - mem_valid = 1, and the mem_* outputs stay stable until mem_ready.
- DATA:
  - On mem_ready, capture mem_rdata into dm_rdata (loads; stores leave it unchanged).
  - Assert dm_done for exactly the next cycle, and go to IDLE.
- FETCH:
  - On mem_ready with ~if_flush, capture if_rdata, pulse if_done the next cycle, and go to IDLE.
  - If if_flush is seen before or with mem_ready, the fetch is not aborted; the memory cannot cancel.
    - Flush with mem_ready in the same cycle: go to IDLE with no if_done.
    - Flush without mem_ready: go to FETCH_KILL.
- FETCH_KILL:
  - Hold the request until mem_ready, then go to IDLE.
  - No if_done; if_rdata is unchanged.
- Latency with a 0-wait memory (mem_ready on the first valid cycle):
  - Request seen in IDLE at cycle N.
  - mem_valid at N+1.
  - done at N+2.
- Throughput: one transaction per 2 cycles minimum (IDLE between transactions).
- mem_valid is deasserted in IDLE and in the done cycle.
- stall_if and stall_mem are combinational from the inputs and the done registers.
- The done pulses are registered, never combinational from mem_ready.
- No starvation guard: data priority is correct because a pending data access stalls the pipeline behind it.

Decomposition:
- Shared package: FSM state encoding (IDLE = 2'd0, DATA = 2'd1, FETCH = 2'd2, FETCH_KILL = 2'd3) and default XLEN/ADDR_W constants.
- Single module; no sub-module is natural at this size.

Test Plan:
- Load, 0-wait: dm_req = 1, dm_we = 0, dm_addr = 0x100, mem_rdata = 0xDEADBEEF with mem_ready on the first valid cycle.
  -> mem_valid at N+1 with mem_addr = 0x100; dm_done = 1 at N+2 with dm_rdata = 0xDEADBEEF; stall_mem high N..N+1, low at N+2.
- Simultaneous requests: if_req (0x40) and dm_req store (0x200, wdata 0x12345678, wstrb 0xF), 2-wait memory.
  -> store issued first, held stable 3 cycles; dm_done; then fetch to 0x40 issued; if_done follows.
- Flush mid-fetch: fetch 0x80, 3-wait memory, if_flush pulsed in the second wait cycle.
  -> FETCH_KILL; mem_valid held until mem_ready; no if_done; if_rdata unchanged; next fetch uses the new if_addr.
- Flush coincident with mem_ready in FETCH -> no if_done; state IDLE the next cycle.
- Held-request hazard: requester keeps if_req = 1 through the if_done cycle.
  -> exactly one memory transaction per request; no duplicate mem_valid in the done cycle.
- Reset mid-DATA: rst_n = 0 during a wait state.
  -> mem_valid = 0 immediately (async); no dm_done after release; first request after reset is serviced normally.
